dmem_bridge: RTL and testbench

//   Memory-stage partner of the execute-stage data request: accepts one registered data access
//   (en/wen/addr/wdata/size/memop) and drives it onto the SRAM-like data bus (req/addr_ok/data_ok).
//   On the write side it waits for the write response; on the read side it waits for, captures,

---
 rtl/dmem_bridge_pkg.sv | 11 +
 rtl/dmem_bridge_load_align.sv | 28 ++
 rtl/dmem_bridge.sv | 115 +++++++++++
 tb/tb_dmem_bridge.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: memop bit indices, FSM states and load kinds shared by the data-memory bridge
package dmem_bridge_pkg;
  localparam int MMOP_W = 12;
  localparam int MOP_LB = 0, MOP_LBU = 1, MOP_LH = 2, MOP_LHU = 3, MOP_LW = 4, MOP_SB = 5;
  localparam int MOP_SH = 6, MOP_SW = 7, MOP_LWL = 8, MOP_LWR = 9, MOP_SWL = 10, MOP_SWR = 11;
  typedef enum logic [2:0] {DB_IDLE, DB_ADDR, DB_WAIT, DB_DONE, DB_DISCARD} db_state_t;
  typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU, LD_WL, LD_WR} ld_kind_t;
  function automatic logic [MMOP_W-1:0] mop_oh(input int i);
    return MMOP_W'(1) << i;
  endfunction
endpackage

// File: rtl/dmem_bridge_load_align.sv
// load_align: little-endian load byte/half selection, sign/zero extension and lwl/lwr merge with rt
module load_align
  import dmem_bridge_pkg::*;
(
  input  ld_kind_t    kind,
  input  logic [1:0]  off,
  input  logic [31:0] rt,
  input  logic [31:0] w,
  output logic [31:0] res
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [4:0]  shl;
  logic [4:0]  shr;
  // select the addressed lane, extend it, or merge the unaligned word with rt
  always_comb begin
    b   = w[{off, 3'b000} +: 8];
    h   = off[1] ? w[31:16] : w[15:0];
    shl = {~off, 3'b000};
    shr = {off, 3'b000};
    res = kind == LD_B  ? {{24{b[7]}}, b} :
          kind == LD_BU ? {24'h0, b} :
          kind == LD_H  ? {{16{h[15]}}, h} :
          kind == LD_HU ? {16'h0, h} :
          kind == LD_WL ? (w << shl) | (rt & ~(32'hffff_ffff << shl)) :
          kind == LD_WR ? (w >> shr) | (rt & ~(32'hffff_ffff >> shr)) : w;
  end
endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: memory-stage data access onto an SRAM-like bus; lwl/lwr/swl/swr enabled by DMEM_BRIDGE_LWLR_EN
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              req_en_i,
  input  logic [3:0]        req_wen_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_addr_lo_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [1:0]        req_size_i,
  input  logic [MMOP_W-1:0] req_memop_i,
  input  logic [DATA_W-1:0] req_rt_i,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [3:0]        data_wstrb_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i,
  output logic              stallreq_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o
);
  db_state_t         state, nxt;
  ld_kind_t          kind, kind_q;
  logic              raw, acc, kill, flush_q, unused;
  logic [3:0]        wen_q;
  logic [1:0]        lo_q, size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rt_q, rdata_q, aligned;
  assign acc    = req_en_i & ~flush_i & (state == DB_IDLE | (state == DB_DONE & ~stall_i));
  assign kill   = flush_q | flush_i;
  assign unused = ^req_memop_i;
  // decode the one-hot memop; without the unaligned feature those ops degrade to plain word accesses
  always_comb begin
    kind = req_memop_i[MOP_LB]  ? LD_B  :
           req_memop_i[MOP_LBU] ? LD_BU :
           req_memop_i[MOP_LH]  ? LD_H  :
           req_memop_i[MOP_LHU] ? LD_HU : LD_W;
`ifdef DMEM_BRIDGE_LWLR_EN
    kind = req_memop_i[MOP_LWL] ? LD_WL : req_memop_i[MOP_LWR] ? LD_WR : kind;
    raw  = 1'b0;
`else
    raw  = |req_memop_i[MOP_SWR:MOP_LWL];
`endif
  end
  load_align u_align (
    .kind (kind_q),
    .off  (lo_q),
    .rt   (rt_q),
    .w    (data_rdata_i),
    .res  (aligned)
  );
  // state register
  always_ff @(posedge clk) state <= rst ? DB_IDLE : nxt;
  // next state: address phase holds until addr_ok, a flush anywhere before data_ok diverts to discard
  always_comb begin
    nxt = state;
    case (state)
      DB_IDLE:    nxt = acc ? DB_ADDR : DB_IDLE;
      DB_ADDR:    nxt = ~data_addr_ok_i ? DB_ADDR : kill ? DB_DISCARD : DB_WAIT;
      DB_WAIT:    nxt = flush_i ? (data_data_ok_i ? DB_IDLE : DB_DISCARD) : data_data_ok_i ? DB_DONE : DB_WAIT;
      DB_DONE:    nxt = flush_i ? DB_IDLE : stall_i ? DB_DONE : acc ? DB_ADDR : DB_IDLE;
      DB_DISCARD: nxt = data_data_ok_i ? DB_IDLE : DB_DISCARD;
      default:    nxt = DB_IDLE;
    endcase
  end
  // state-decoded handshake and status outputs
  always_comb begin
    data_req_o = state == DB_ADDR;
    stallreq_o = state inside {DB_ADDR, DB_WAIT, DB_DISCARD};
    rvalid_o   = state == DB_DONE & ~|wen_q & ~flush_i;
  end
  assign data_wr_o    = |wen_q;
  assign data_size_o  = size_q;
  assign data_addr_o  = addr_q | ADDR_W'(lo_q);
  assign data_wstrb_o = wen_q;
  assign data_wdata_o = wdata_q;
  assign rdata_o      = rdata_q;
  // request capture on acceptance, flush tracking in the address phase, load result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= '0;
      addr_q  <= '0;
      lo_q    <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      kind_q  <= LD_W;
      rt_q    <= '0;
      flush_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (acc) begin
        wen_q   <= (raw && |req_wen_i) ? 4'hf : req_wen_i;
        addr_q  <= req_addr_i;
        lo_q    <= raw ? 2'd0 : req_addr_lo_i;
        wdata_q <= req_wdata_i;
        size_q  <= raw ? 2'd2 : req_size_i;
        kind_q  <= kind;
        rt_q    <= req_rt_i;
      end
      flush_q <= state == DB_ADDR & kill;
      if (state == DB_WAIT & data_data_ok_i & ~flush_i & ~|wen_q) rdata_q <= aligned;
    end
  end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed scoreboard bench for dmem_bridge
module tb_dmem_bridge;
  import dmem_bridge_pkg::*;
  logic              clk = 1'b0;
  logic              rst, flush_i, stall_i, req_en_i;
  logic [3:0]        req_wen_i;
  logic [31:0]       req_addr_i, req_wdata_i, req_rt_i, data_rdata_i;
  logic [1:0]        req_addr_lo_i, req_size_i;
  logic [MMOP_W-1:0] req_memop_i;
  logic              data_addr_ok_i, data_data_ok_i;
  logic              data_req_o, data_wr_o, stallreq_o, rvalid_o;
  logic [1:0]        data_size_o;
  logic [31:0]       data_addr_o, data_wdata_o, rdata_o;
  logic [3:0]        data_wstrb_o;
  int                nvec = 0;
  int                nerr = 0;
  logic [31:0]       sb[$];

  dmem_bridge dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i), .req_en_i(req_en_i),
    .req_wen_i(req_wen_i), .req_addr_i(req_addr_i), .req_addr_lo_i(req_addr_lo_i),
    .req_wdata_i(req_wdata_i), .req_size_i(req_size_i), .req_memop_i(req_memop_i),
    .req_rt_i(req_rt_i), .data_req_o(data_req_o), .data_wr_o(data_wr_o),
    .data_size_o(data_size_o), .data_addr_o(data_addr_o), .data_wstrb_o(data_wstrb_o),
    .data_wdata_o(data_wdata_o), .data_addr_ok_i(data_addr_ok_i),
    .data_data_ok_i(data_data_ok_i), .data_rdata_i(data_rdata_i),
    .stallreq_o(stallreq_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] e;
    e = sb.size() != 0 ? sb.pop_front() : 32'hxxxx_xxxx;
    chk(tag, rdata_o, e);
  endtask

  task automatic set_req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] sz, input int mop, input logic [31:0] rt);
    req_en_i      = 1'b1;
    req_wen_i     = wen;
    req_addr_i    = {addr[31:2], 2'b00};
    req_addr_lo_i = addr[1:0];
    req_wdata_i   = wdata;
    req_size_i    = sz;
    req_memop_i   = mop_oh(mop);
    req_rt_i      = rt;
  endtask

  task automatic do_load(input logic [31:0] addr, input int mop, input logic [1:0] sz,
                         input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] ex,
                         input string tag);
    set_req(4'h0, addr, 32'h0, sz, mop, rt);
    sb.push_back(ex);
    tick;
    req_en_i = 1'b0;
    chk({tag, "_req"}, 32'(data_req_o), 1);
    data_addr_ok_i = 1'b1;
    tick;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b1;
    data_rdata_i   = rd;
    tick;
    data_data_ok_i = 1'b0;
    chk({tag, "_rvalid"}, 32'(rvalid_o), 1);
    pop_chk(tag);
    tick;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0; req_en_i = 1'b0; req_wen_i = '0;
    req_addr_i = '0; req_addr_lo_i = '0; req_wdata_i = '0; req_size_i = '0;
    req_memop_i = '0; req_rt_i = '0; data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0;
    data_rdata_i = '0;
    tick;
    tick;
    chk("rst_req", 32'(data_req_o), 0);
    chk("rst_wr", 32'(data_wr_o), 0);
    chk("rst_addr", data_addr_o, 0);
    chk("rst_stall", 32'(stallreq_o), 0);
    chk("rst_rvalid", 32'(rvalid_o), 0);
    chk("rst_rdata", rdata_o, 0);
    rst = 1'b0;
    tick;

    // lb @0x1003, addr_ok c1, data_ok c2, rvalid c3
    set_req(4'h0, 32'h1003, 32'h0, 2'd0, MOP_LB, 32'h0);
    sb.push_back(32'hffff_ff80);
    tick;
    req_en_i = 1'b0;
    chk("lb_c1_req", 32'(data_req_o), 1);
    chk("lb_c1_stall", 32'(stallreq_o), 1);
    chk("lb_addr", data_addr_o, 32'h1003);
    chk("lb_size", 32'(data_size_o), 0);
    chk("lb_wr", 32'(data_wr_o), 0);
    data_addr_ok_i = 1'b1;
    tick;
    data_addr_ok_i = 1'b0;
    chk("lb_c2_req", 32'(data_req_o), 0);
    chk("lb_c2_stall", 32'(stallreq_o), 1);
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'h80ff_0000;
    tick;
    data_data_ok_i = 1'b0;
    chk("lb_c3_rvalid", 32'(rvalid_o), 1);
    chk("lb_c3_stall", 32'(stallreq_o), 0);
    pop_chk("lb_data");
    tick;
    chk("lb_c4_rvalid", 32'(rvalid_o), 0);

    // sw @0x2000 with addr_ok held off 3 cycles
    set_req(4'hf, 32'h2000, 32'hdead_beef, 2'd2, MOP_SW, 32'h0);
    tick;
    req_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sw_req", 32'(data_req_o), 1);
      chk("sw_addr", data_addr_o, 32'h2000);
      chk("sw_wdata", data_wdata_o, 32'hdead_beef);
      chk("sw_wstrb", 32'(data_wstrb_o), 32'hf);
      chk("sw_wr", 32'(data_wr_o), 1);
      chk("sw_rvalid", 32'(rvalid_o), 0);
      tick;
    end
    data_addr_ok_i = 1'b1;
    tick;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'h5555_5555;
    tick;
    data_data_ok_i = 1'b0;
    chk("sw_done_rvalid", 32'(rvalid_o), 0);
    chk("sw_done_stall", 32'(stallreq_o), 0);
    chk("sw_rdata_kept", rdata_o, 32'hffff_ff80);
    tick;

    // lh with flush in ADDR: request held to addr_ok, then discarded
    set_req(4'h0, 32'h3002, 32'h0, 2'd1, MOP_LH, 32'h0);
    tick;
    req_en_i = 1'b0;
    flush_i  = 1'b1;
    tick;
    flush_i  = 1'b0;
    chk("fl_req_a", 32'(data_req_o), 1);
    tick;
    chk("fl_req_b", 32'(data_req_o), 1);
    data_addr_ok_i = 1'b1;
    tick;
    data_addr_ok_i = 1'b0;
    chk("fl_disc_stall", 32'(stallreq_o), 1);
    chk("fl_disc_req", 32'(data_req_o), 0);
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'h1234_5678;
    tick;
    data_data_ok_i = 1'b0;
    chk("fl_idle_stall", 32'(stallreq_o), 0);
    chk("fl_rvalid", 32'(rvalid_o), 0);
    chk("fl_rdata_kept", rdata_o, 32'hffff_ff80);
    tick;
    chk("fl_after_rvalid", 32'(rvalid_o), 0);

    // lhu completes under stall, then back-to-back lw accepted from DONE
    set_req(4'h0, 32'h4002, 32'h0, 2'd1, MOP_LHU, 32'h0);
    sb.push_back(32'h0000_89ab);
    tick;
    req_en_i = 1'b0;
    data_addr_ok_i = 1'b1;
    tick;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'h89ab_0000;
    stall_i        = 1'b1;
    tick;
    data_data_ok_i = 1'b0;
    pop_chk("lhu_data");
    for (int i = 0; i < 4; i++) begin
      chk("lhu_hold_rvalid", 32'(rvalid_o), 1);
      chk("lhu_hold_rdata", rdata_o, 32'h0000_89ab);
      tick;
    end
    stall_i = 1'b0;
    set_req(4'h0, 32'h5000, 32'h0, 2'd2, MOP_LW, 32'h0);
    sb.push_back(32'hcafe_f00d);
    tick;
    req_en_i = 1'b0;
    chk("b2b_req", 32'(data_req_o), 1);
    chk("b2b_addr", data_addr_o, 32'h5000);
    chk("b2b_rvalid", 32'(rvalid_o), 0);
    data_addr_ok_i = 1'b1;
    tick;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'hcafe_f00d;
    tick;
    data_data_ok_i = 1'b0;
    chk("b2b_rvalid_done", 32'(rvalid_o), 1);
    pop_chk("b2b_data");
    tick;

    // alignment and extension patterns
`ifdef DMEM_BRIDGE_LWLR_EN
    do_load(32'h6001, MOP_LWL, 2'd2, 32'h1122_3344, 32'haabb_ccdd, 32'hccdd_3344, "lwl1");
    do_load(32'h6002, MOP_LWR, 2'd2, 32'h1122_3344, 32'haabb_ccdd, 32'h1122_aabb, "lwr2");
`else
    do_load(32'h6001, MOP_LWL, 2'd2, 32'h1122_3344, 32'haabb_ccdd, 32'haabb_ccdd, "lwl1");
    do_load(32'h6002, MOP_LWR, 2'd2, 32'h1122_3344, 32'haabb_ccdd, 32'haabb_ccdd, "lwr2");
`endif
    do_load(32'h7001, MOP_LBU, 2'd0, 32'h0, 32'h0000_f100, 32'h0000_00f1, "lbu1");
    do_load(32'h7000, MOP_LH,  2'd1, 32'h0, 32'h0000_8001, 32'hffff_8001, "lh0");
    do_load(32'h7002, MOP_LB,  2'd0, 32'h0, 32'h0071_0000, 32'h0000_0071, "lb2");

    // flush while waiting for data
    set_req(4'h0, 32'h9000, 32'h0, 2'd2, MOP_LW, 32'h0);
    tick;
    req_en_i = 1'b0;
    data_addr_ok_i = 1'b1;
    tick;
    data_addr_ok_i = 1'b0;
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    chk("wfl_stall", 32'(stallreq_o), 1);
    chk("wfl_rvalid", 32'(rvalid_o), 0);
    data_data_ok_i = 1'b1;
    data_rdata_i   = 32'h0bad_0bad;
    tick;
    data_data_ok_i = 1'b0;
    chk("wfl_idle_stall", 32'(stallreq_o), 0);
    chk("wfl_rvalid_idle", 32'(rvalid_o), 0);

    // reset in WAIT
    set_req(4'h0, 32'h8000, 32'h0, 2'd2, MOP_LW, 32'h0);
    tick;
    req_en_i = 1'b0;
    data_addr_ok_i = 1'b1;
    tick;
    data_addr_ok_i = 1'b0;
    chk("rw_wait_stall", 32'(stallreq_o), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rw_req", 32'(data_req_o), 0);
    chk("rw_stall", 32'(stallreq_o), 0);
    chk("rw_rdata", rdata_o, 0);
    chk("rw_rvalid", 32'(rvalid_o), 0);
    do_load(32'h8004, MOP_LW, 2'd2, 32'h0, 32'h0102_0304, 32'h0102_0304, "rw_recover");

    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
